// File: rtl/memory1_pkg.sv
// Shared types for the memory1 stage: stage bundles, forward request, access size and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package memory1_pkg;

    typedef logic [31:0] u32_t;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SENT = 2'd2
    } mem1_state_t;

    typedef struct packed {
        u32_t       pc;
        u32_t       pc_plus4;
        u32_t       ex_out;
        u32_t       st_data;
        logic [4:0] rd;
        logic       is_wr_rd;
        logic       is_wr_rd_pc_plus4;
        logic       is_mem;
        logic       is_store;
        byte_type_t byte_type;
        logic       is_signed;
        logic       is_flush;
    } execute_memory1_pass_t;

    typedef struct packed {
        u32_t       pc;
        u32_t       pc_plus4;
        u32_t       ex_out;
        logic [4:0] rd;
        logic       is_wr_rd;
        logic       is_wr_rd_pc_plus4;
        logic       is_mem;
        logic       is_store;
        byte_type_t byte_type;
        logic       is_signed;
        logic       is_flush;
        logic [1:0] byte_en;
        logic       excp_ale;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
        u32_t       data;
    } forward_req_t;

    // True when the access size does not fit the low address bits.
    function automatic logic is_misaligned(input byte_type_t bt, input logic [1:0] lo);
        return ((bt == HALF_WORD) && lo[0]) || ((bt == WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory1_st_align.sv
// Store lane replication and byte-strobe generation for the dcache write port.
// Latency: combinational.
// Backpressure: none; outputs follow inputs.
import memory1_pkg::*;

module st_align (
    input  byte_type_t  byte_type,
    input  logic        is_store,
    input  logic [1:0]  addr,
    input  u32_t        st_data,
    output u32_t        wr_data,
    output logic [3:0]  wr_strb
);

    // Replicate the stored quantity across lanes and pick the strobes it lands on.
    always_comb begin
        wr_data = st_data;
        wr_strb = 4'b0000;
        case (byte_type)
            BYTE: begin
                wr_data = {4{st_data[7:0]}};
                wr_strb = 4'b0001 << addr;
            end
            HALF_WORD: begin
                wr_data = {2{st_data[15:0]}};
                wr_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            WORD: begin
                wr_data = st_data;
                wr_strb = 4'b1111;
            end
            default: begin
                wr_data = st_data;
                wr_strb = 4'b0000;
            end
        endcase
        if (!is_store) begin
            wr_strb = 4'b0000;
        end
    end

endmodule

// File: rtl/memory1.sv
// Memory1 stage: holds the execute bundle, issues one dcache request per memory op, forwards ALU results.
// Latency: request valid the cycle after the bundle is registered; handshake with ready=1 adds no cycles.
// Backpressure: ready low raises dcache_req_stall and bubbles memory2; MEMORY1_ALIGN_CHECK_EN enables misalign traps.
import memory1_pkg::*;

module memory1 (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_stall,
    input  logic                  is_flush,
    input  execute_memory1_pass_t pass_in,
    output memory1_memory2_pass_t pass_out,
    output forward_req_t          fwd_req,
    output logic                  dcache_req_valid,
    input  logic                  dcache_req_ready,
    output u32_t                  dcache_addr,
    output logic                  dcache_is_wr,
    output u32_t                  dcache_wr_data,
    output logic [3:0]            dcache_wr_strb,
    output logic                  dcache_req_stall
);

    execute_memory1_pass_t pass_in_r;
    mem1_state_t           state;
    mem1_state_t           state_nxt;
    logic                  mem1_flush;
    logic                  ale;
    logic                  done;
    logic                  go;

    // Input register; reset leaves a bubble so nothing downstream acts on stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_in_r          <= '0;
            pass_in_r.is_flush <= 1'b1;
        end else if (!is_stall) begin
            pass_in_r <= pass_in;
        end
    end

    assign mem1_flush = is_flush | pass_in_r.is_flush;

`ifdef MEMORY1_ALIGN_CHECK_EN
    assign ale = pass_in_r.is_mem & is_misaligned(pass_in_r.byte_type, pass_in_r.ex_out[1:0]);
`else
    assign ale = 1'b0;
`endif

    // A request already handed over for the held instruction must not be reissued.
    assign done = (state == SENT);
    assign go   = pass_in_r.is_mem & ~mem1_flush & ~ale & ~done;

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and request valid; a flush drops valid at once and returns to IDLE.
    always_comb begin
        state_nxt        = state;
        dcache_req_valid = 1'b0;
        case (state)
            IDLE: begin
                dcache_req_valid = go;
                if (go) begin
                    if (dcache_req_ready) begin
                        state_nxt = is_stall ? SENT : IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                dcache_req_valid = ~mem1_flush;
                if (dcache_req_ready) begin
                    state_nxt = is_stall ? SENT : IDLE;
                end
            end
            SENT: begin
                if (!is_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (is_flush) begin
            state_nxt = IDLE;
        end
    end

    assign dcache_req_stall = dcache_req_valid & ~dcache_req_ready;
    assign dcache_addr      = pass_in_r.ex_out;
    assign dcache_is_wr     = pass_in_r.is_store;

    st_align u_st_align (
        .byte_type (pass_in_r.byte_type),
        .is_store  (pass_in_r.is_store),
        .addr      (pass_in_r.ex_out[1:0]),
        .st_data   (pass_in_r.st_data),
        .wr_data   (dcache_wr_data),
        .wr_strb   (dcache_wr_strb)
    );

    // Forward non-memory register writes back to execute.
    always_comb begin
        fwd_req       = '0;
        fwd_req.valid = pass_in_r.is_wr_rd & ~pass_in_r.is_mem & ~mem1_flush;
        fwd_req.idx   = pass_in_r.rd;
        fwd_req.data  = pass_in_r.is_wr_rd_pc_plus4 ? pass_in_r.pc_plus4 : pass_in_r.ex_out;
    end

    // Bundle to memory2; a bubble is sent while the dcache has not accepted the request.
    always_comb begin
        pass_out                   = '0;
        pass_out.pc                = pass_in_r.pc;
        pass_out.pc_plus4          = pass_in_r.pc_plus4;
        pass_out.ex_out            = pass_in_r.ex_out;
        pass_out.rd                = pass_in_r.rd;
        pass_out.is_wr_rd          = pass_in_r.is_wr_rd;
        pass_out.is_wr_rd_pc_plus4 = pass_in_r.is_wr_rd_pc_plus4;
        pass_out.is_mem            = pass_in_r.is_mem & ~ale;
        pass_out.is_store          = pass_in_r.is_store;
        pass_out.byte_type         = pass_in_r.byte_type;
        pass_out.is_signed         = pass_in_r.is_signed;
        pass_out.is_flush          = mem1_flush | dcache_req_stall;
        pass_out.byte_en           = pass_in_r.ex_out[1:0];
        pass_out.excp_ale          = ale;
    end

endmodule

// File: tb/tb_memory1.sv
// Directed bench for memory1: store formatting, wait/sent sequencing, flush, reset and alignment.
// Latency: n/a.
// Backpressure: dcache ready and ctrl stall driven by the stimulus sequence.
import memory1_pkg::*;

module tb_memory1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  is_stall;
    logic                  is_flush;
    execute_memory1_pass_t pass_in;
    memory1_memory2_pass_t pass_out;
    forward_req_t          fwd_req;
    logic                  dcache_req_valid;
    logic                  dcache_req_ready;
    u32_t                  dcache_addr;
    logic                  dcache_is_wr;
    u32_t                  dcache_wr_data;
    logic [3:0]            dcache_wr_strb;
    logic                  dcache_req_stall;

    int checks   = 0;
    int failures = 0;
    int hs       = 0;
    int hs0;

    memory1 dut (
        .clk              (clk),
        .rst              (rst),
        .is_stall         (is_stall),
        .is_flush         (is_flush),
        .pass_in          (pass_in),
        .pass_out         (pass_out),
        .fwd_req          (fwd_req),
        .dcache_req_valid (dcache_req_valid),
        .dcache_req_ready (dcache_req_ready),
        .dcache_addr      (dcache_addr),
        .dcache_is_wr     (dcache_is_wr),
        .dcache_wr_data   (dcache_wr_data),
        .dcache_wr_strb   (dcache_wr_strb),
        .dcache_req_stall (dcache_req_stall)
    );

    always #5 clk = ~clk;

    // Count dcache handshakes.
    always @(posedge clk) begin
        if (dcache_req_valid && dcache_req_ready) hs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic execute_memory1_pass_t mk(input byte_type_t bt, input logic st,
                                                 input u32_t addr, input u32_t d);
        execute_memory1_pass_t p;
        p           = '0;
        p.pc        = 32'h0000_0100;
        p.pc_plus4  = 32'h0000_0104;
        p.ex_out    = addr;
        p.st_data   = d;
        p.byte_type = bt;
        p.is_store  = st;
        p.is_mem    = 1'b1;
        p.is_wr_rd  = ~st;
        p.rd        = 5'd7;
        return p;
    endfunction

    function automatic execute_memory1_pass_t bubble();
        execute_memory1_pass_t p;
        p          = '0;
        p.is_flush = 1'b1;
        return p;
    endfunction

    function automatic execute_memory1_pass_t alu(input logic use_pc4);
        execute_memory1_pass_t p;
        p                   = '0;
        p.pc_plus4          = 32'h0000_0204;
        p.ex_out            = 32'h0000_1234;
        p.rd                = 5'd5;
        p.is_wr_rd          = 1'b1;
        p.is_wr_rd_pc_plus4 = use_pc4;
        return p;
    endfunction

    initial begin
        rst = 1'b1; is_stall = 1'b0; is_flush = 1'b0;
        dcache_req_ready = 1'b0; pass_in = bubble();
        tick(); tick();
        #1;
        chk("rst_valid",      32'(dcache_req_valid),  32'd0);
        chk("rst_req_stall",  32'(dcache_req_stall),  32'd0);
        chk("rst_fwd_valid",  32'(fwd_req.valid),     32'd0);
        chk("rst_out_flush",  32'(pass_out.is_flush), 32'd1);
        chk("rst_excp_ale",   32'(pass_out.excp_ale), 32'd0);
        chk("rst_state",      32'(dut.state),         32'(IDLE));
        rst = 1'b0;

        // Byte store to lane 3, accepted at once.
        pass_in = mk(BYTE, 1'b1, 32'h0000_1003, 32'h0000_00AB);
        dcache_req_ready = 1'b1;
        tick();
        pass_in = bubble(); #1;
        chk("sb_valid",   32'(dcache_req_valid), 32'd1);
        chk("sb_strb",    32'(dcache_wr_strb),   32'h8);
        chk("sb_data",    dcache_wr_data,        32'hABAB_ABAB);
        chk("sb_is_wr",   32'(dcache_is_wr),     32'd1);
        chk("sb_stall",   32'(dcache_req_stall), 32'd0);
        chk("sb_addr",    dcache_addr,           32'h0000_1003);
        chk("sb_byte_en", 32'(pass_out.byte_en), 32'd3);
        chk("sb_flush",   32'(pass_out.is_flush), 32'd0);

        // Byte store to lane 1, half store to upper half, word store.
        tick();
        pass_in = mk(BYTE, 1'b1, 32'h0000_1001, 32'h0000_00CD);
        tick(); pass_in = bubble(); #1;
        chk("sb1_strb", 32'(dcache_wr_strb), 32'h2);
        chk("sb1_data", dcache_wr_data,      32'hCDCD_CDCD);
        tick();
        pass_in = mk(HALF_WORD, 1'b1, 32'h0000_3002, 32'h0000_1234);
        tick(); pass_in = bubble(); #1;
        chk("sh_strb", 32'(dcache_wr_strb), 32'hC);
        chk("sh_data", dcache_wr_data,      32'h1234_1234);
        tick();
        pass_in = mk(WORD, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        tick(); pass_in = bubble(); #1;
        chk("sw_strb", 32'(dcache_wr_strb), 32'hF);
        chk("sw_data", dcache_wr_data,      32'hDEAD_BEEF);
        tick();

        // Word load with ready low for three cycles.
        pass_in = mk(WORD, 1'b0, 32'h0000_2000, 32'h0);
        dcache_req_ready = 1'b0;
        tick();
        pass_in = bubble(); is_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_valid", 32'(dcache_req_valid),  32'd1);
            chk("lw_wait_addr",  dcache_addr,            32'h0000_2000);
            chk("lw_wait_stall", 32'(dcache_req_stall),  32'd1);
            chk("lw_wait_flush", 32'(pass_out.is_flush), 32'd1);
            tick();
        end
        dcache_req_ready = 1'b1; is_stall = 1'b0; #1;
        chk("lw_acc_valid", 32'(dcache_req_valid),  32'd1);
        chk("lw_acc_addr",  dcache_addr,            32'h0000_2000);
        chk("lw_acc_stall", 32'(dcache_req_stall),  32'd0);
        chk("lw_acc_flush", 32'(pass_out.is_flush), 32'd0);
        chk("lw_acc_strb",  32'(dcache_wr_strb),    32'd0);
        chk("lw_acc_is_wr", 32'(dcache_is_wr),      32'd0);
        tick(); #1;
        chk("lw_done_valid", 32'(dcache_req_valid), 32'd0);
        chk("lw_done_state", 32'(dut.state),        32'(IDLE));

        // Load accepted while stalled: one handshake, then silent in SENT.
        pass_in = mk(WORD, 1'b0, 32'h0000_2004, 32'h0);
        hs0 = hs;
        tick();
        pass_in = bubble(); is_stall = 1'b1; #1;
        chk("sent_issue_valid", 32'(dcache_req_valid), 32'd1);
        tick(); #1;
        chk("sent_state1", 32'(dut.state),        32'(SENT));
        chk("sent_valid1", 32'(dcache_req_valid), 32'd0);
        tick(); #1;
        chk("sent_valid2", 32'(dcache_req_valid), 32'd0);
        is_stall = 1'b0; #1;
        chk("sent_valid3", 32'(dcache_req_valid), 32'd0);
        tick(); #1;
        chk("sent_exit_state", 32'(dut.state), 32'(IDLE));
        chk("sent_handshakes", 32'(hs - hs0),  32'd1);

        // Flush while waiting.
        pass_in = mk(WORD, 1'b0, 32'h0000_2008, 32'h0);
        dcache_req_ready = 1'b0;
        tick();
        pass_in = bubble(); is_stall = 1'b1; #1;
        chk("fl_pre_valid", 32'(dcache_req_valid), 32'd1);
        tick(); #1;
        chk("fl_wait_state", 32'(dut.state), 32'(WAIT));
        is_flush = 1'b1; is_stall = 1'b0; #1;
        chk("fl_valid",     32'(dcache_req_valid),  32'd0);
        chk("fl_out_flush", 32'(pass_out.is_flush), 32'd1);
        chk("fl_stall",     32'(dcache_req_stall),  32'd0);
        tick();
        is_flush = 1'b0; #1;
        chk("fl_next_state", 32'(dut.state),        32'(IDLE));
        chk("fl_next_valid", 32'(dcache_req_valid), 32'd0);

        // Forwarding of ALU and link results, and kill by flush.
        pass_in = alu(1'b0);
        tick();
        pass_in = bubble(); #1;
        chk("fwd_valid", 32'(fwd_req.valid), 32'd1);
        chk("fwd_idx",   32'(fwd_req.idx),   32'd5);
        chk("fwd_data",  fwd_req.data,       32'h0000_1234);
        is_flush = 1'b1; #1;
        chk("fwd_flush_valid", 32'(fwd_req.valid), 32'd0);
        is_flush = 1'b0;
        pass_in = alu(1'b1);
        tick();
        pass_in = bubble(); #1;
        chk("fwd_pc4_data", fwd_req.data, 32'h0000_0204);
        tick();

        // Misaligned half-word load.
        pass_in = mk(HALF_WORD, 1'b0, 32'h0000_3001, 32'h0);
        dcache_req_ready = 1'b1;
        tick();
        pass_in = bubble(); #1;
`ifdef MEMORY1_ALIGN_CHECK_EN
        chk("ale_valid",  32'(dcache_req_valid),  32'd0);
        chk("ale_excp",   32'(pass_out.excp_ale), 32'd1);
        chk("ale_is_mem", 32'(pass_out.is_mem),   32'd0);
`else
        chk("ale_valid",  32'(dcache_req_valid),  32'd1);
        chk("ale_strb",   32'(dcache_wr_strb),    32'd0);
        chk("ale_excp",   32'(pass_out.excp_ale), 32'd0);
        chk("ale_is_mem", 32'(pass_out.is_mem),   32'd1);
`endif
        tick();

        // Reset pulsed while waiting.
        pass_in = mk(WORD, 1'b0, 32'h0000_200C, 32'h0);
        dcache_req_ready = 1'b0;
        tick();
        pass_in = bubble(); is_stall = 1'b1;
        tick(); #1;
        chk("rw_wait_valid", 32'(dcache_req_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; is_stall = 1'b0; #1;
        chk("rw_valid",     32'(dcache_req_valid),  32'd0);
        chk("rw_out_flush", 32'(pass_out.is_flush), 32'd1);
        chk("rw_fwd_valid", 32'(fwd_req.valid),     32'd0);
        chk("rw_state",     32'(dut.state),         32'(IDLE));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
